mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares a single SRAM-like memory port between the IF-stage instruction fetch
//  and the MEM-stage load/store path of the 5-stage pipeline.
//  Grants one requester at a time, at most one outstanding transaction.
//  Returns read data and a one-cycle ok pulse, and raises per-stage stall requests
//  to the hazard unit. Supports cancel of a fetch on exception/eret redirect.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  32  data width; strobe width is DATA_W/8
// PORTS
//  clk          in   1         clock
//  rst          in   1         synchronous reset, active high
//  inst_req     in   1         fetch request, level, held until inst_ok
//  inst_addr    in   ADDR_W    fetch address (PCF)
//  inst_cancel  in   1         drop the fetch in flight (exception/eret redirect)
//  inst_rdata   out  DATA_W    fetched instruction, valid with inst_ok
//  inst_ok      out  1         one-cycle completion pulse for the fetch
//  data_req     in   1         load/store request, level, held until data_ok
//  data_wen     in   DATA_W/8  byte strobes; 0 = load
//  data_addr    in   ADDR_W    data address (MemAddrM)
//  data_wdata   in   DATA_W    store data (already byte-lane aligned)
//  data_rdata   out  DATA_W    load data, valid with data_ok
//  data_ok      out  1         one-cycle completion pulse for the data access
//  stall_if     out  1         inst_req & ~inst_ok
//  stall_mem    out  1         data_req & ~data_ok
//  mem_req      out  1         shared-port request
//  mem_wr       out  1         1 = write
//  mem_wstrb    out  DATA_W/8  write strobes
//  mem_addr     out  ADDR_W    shared-port address
//  mem_wdata    out  DATA_W    shared-port write data
//  mem_addr_ok  in   1         address accepted this cycle
//  mem_rdata    in   DATA_W    read data
//  mem_data_ok  in   1         data returned / write done this cycle
// BEHAVIOUR
//  - FSM states: IDLE, REQ, WAIT, DONE.
//  - An owner flag (I or D) is latched at grant.
//  - All mem_* outputs, *_ok and *_rdata are registered.
//  - stall_* are combinational.
//  - Reset clears to IDLE, owner=I, cancel flag=0, and drives every registered
//    output to 0. Reset mid-transaction abandons it; the memory side is reset
//    with the core.
//  - IDLE: if data_req, grant D. Else if inst_req, grant I. Data has fixed priority.
//    On grant, latch addr/wdata/wstrb (wstrb=0 for I) and set mem_wr=|wstrb;
//    set mem_req=1 and go to REQ. With no request, stay in IDLE.
//  - REQ: mem_req held high with stable addr/wdata/wstrb; mem_req is never
//    withdrawn before mem_addr_ok. On mem_addr_ok, drop mem_req and go to WAIT.
//  - WAIT: on mem_data_ok, capture mem_rdata into the owner's rdata register
//    and go to DONE.
//  - DONE: owner's ok=1 for exactly this cycle, then go to IDLE.
//    For a store, data_rdata is unchanged.
//  - Minimum latency with addr_ok and data_ok each in their first cycle:
//    req seen at cycle 0, mem_req at cycle 1, ok at cycle 3.
//  - A requester sees ok in DONE and advances on that edge, so the arbiter samples
//    a fresh request in the IDLE that follows. This gives no double service.
//  - inst_cancel in any cycle while owner=I and state is REQ, WAIT or DONE sets the
//    cancel flag. The transaction still completes on the bus. In DONE, inst_ok is
//    suppressed and inst_rdata is not updated. The flag clears on entering IDLE.
//  - inst_cancel while IDLE or owner=D has no effect.
//  - Simultaneous inst_req and data_req in IDLE: D is served first. I waits in
//    IDLE and is granted the next IDLE with no D request.
//  - A request arriving during a transaction is not sampled until IDLE.
//  - mem_data_ok in REQ (before addr_ok) is ignored.
// TESTING
//  - Single fetch (addr 0xBFC00000, memory returns 0x24020001, addr_ok and data_ok
//    immediate) -> mem_req at cycle 1 with mem_wr=0; inst_ok=1 and
//    inst_rdata=0x24020001 at cycle 3 only; stall_if=1 during cycles 0-2.
//  - Same-cycle inst_req and data_req store (wen=4'b0011, addr 0x80000010,
//    wdata 0x0000BEEF) -> first mem_req has mem_wr=1, wstrb=0011; data_ok before
//    any fetch on the bus; fetch then served with inst_ok one cycle after its data_ok.
//  - Memory holds addr_ok low 3 cycles, then data_ok after 2 more -> mem_req high
//    for exactly 4 cycles; addr stable throughout; ok exactly one cycle.
//  - Fetch with inst_cancel pulsed in WAIT -> bus transaction completes; inst_ok
//    never asserted; inst_rdata keeps its previous value.
//  - Reset asserted while in WAIT -> next cycle in IDLE; mem_req, inst_ok and
//    data_ok are 0; a late mem_data_ok is ignored; a fresh fetch then completes
//    normally.
//  - Back-to-back loads (data_req held through 2 accesses) -> 2 distinct data_ok
//    pulses separated by at least 4 cycles; no inst grant between them while
//    data_req stays high.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch (I) and the
// load/store path (D). One transaction at a time, data has fixed priority.
// Completion is signalled with a one-cycle registered ok pulse per side.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch side
  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  input  logic                  inst_cancel,
  output logic [DATA_W-1:0]     inst_rdata,
  output logic                  inst_ok,
  // load/store side
  input  logic                  data_req,
  input  logic [DATA_W/8-1:0]   data_wen,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  data_ok,
  // hazard unit
  output logic                  stall_if,
  output logic                  stall_mem,
  // shared memory port
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_addr_ok,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_data_ok
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                cancel_q, cancel_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_wr_q, mem_wr_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic                inst_ok_q, inst_ok_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                data_ok_q, data_ok_d;
  logic                cancel_hit;

  // A cancel only matters while a fetch owns the port.
  assign cancel_hit = inst_cancel && (owner_q == OWNER_I) && (state_q != S_IDLE);

  // State register and all registered outputs; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWNER_I;
      cancel_q     <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_wstrb_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_rdata_q <= '0;
      inst_ok_q    <= 1'b0;
      data_rdata_q <= '0;
      data_ok_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cancel_q     <= cancel_d;
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      inst_ok_q    <= inst_ok_d;
      data_rdata_q <= data_rdata_d;
      data_ok_q    <= data_ok_d;
    end
  end

  // Next-state and next-output logic: grant, address phase, data phase, done.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cancel_d     = cancel_q;
    mem_req_d    = mem_req_q;
    mem_wr_d     = mem_wr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_rdata_d = inst_rdata_q;
    inst_ok_d    = 1'b0;
    data_rdata_d = data_rdata_q;
    data_ok_d    = 1'b0;

    if (cancel_hit) begin
      cancel_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        cancel_d = 1'b0;
        if (data_req) begin
          owner_d     = OWNER_D;
          mem_addr_d  = data_addr;
          mem_wdata_d = data_wdata;
          mem_wstrb_d = data_wen;
          mem_wr_d    = |data_wen;
          mem_req_d   = 1'b1;
          state_d     = S_REQ;
        end else if (inst_req) begin
          owner_d     = OWNER_I;
          mem_addr_d  = inst_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
          mem_wr_d    = 1'b0;
          mem_req_d   = 1'b1;
          state_d     = S_REQ;
        end
      end

      // Hold the request stable until the memory takes the address.
      S_REQ: begin
        if (mem_addr_ok) begin
          mem_req_d = 1'b0;
          state_d   = S_WAIT;
        end
      end

      // Capture the response; a cancelled fetch completes silently.
      S_WAIT: begin
        if (mem_data_ok) begin
          state_d = S_DONE;
          if (owner_q == OWNER_D) begin
            data_ok_d = 1'b1;
            if (!mem_wr_q) begin
              data_rdata_d = mem_rdata;
            end
          end else if (!(cancel_q || cancel_hit)) begin
            inst_ok_d    = 1'b1;
            inst_rdata_d = mem_rdata;
          end
        end
      end

      // ok is visible this cycle; the requester advances on this edge.
      S_DONE: begin
        cancel_d = 1'b0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_req    = mem_req_q;
  assign mem_wr     = mem_wr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign inst_rdata = inst_rdata_q;
  assign inst_ok    = inst_ok_q;
  assign data_rdata = data_rdata_q;
  assign data_ok    = data_ok_q;

  // Stall requests go straight to the hazard unit.
  assign stall_if  = inst_req & ~inst_ok_q;
  assign stall_mem = data_req & ~data_ok_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small memory responder.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_cancel = 1'b0;
  logic [31:0] inst_rdata;
  logic        inst_ok;
  logic        data_req = 1'b0;
  logic [3:0]  data_wen = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_ok;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_data_ok = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // responder controls
  int          resp_aok_dly = 0;
  int          resp_dok_dly = 0;
  bit          resp_manual = 1'b0;
  logic        man_aok = 1'b0;
  logic        man_dok = 1'b0;
  logic [31:0] man_rdata = '0;
  int          resp_ph = 0;
  int          resp_cnt = 0;
  logic [31:0] resp_addr = '0;
  int          dok_count = 0;

  logic [31:0] exp_inst_rdata = '0;
  logic [31:0] exp_data_rdata = '0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_rdata(inst_rdata), .inst_ok(inst_ok),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ok(data_ok),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_rdata(mem_rdata), .mem_data_ok(mem_data_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h24020001;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory responder: drives handshakes on the falling edge.
  always @(negedge clk) begin
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    if (resp_manual) begin
      mem_addr_ok = man_aok;
      mem_data_ok = man_dok;
      mem_rdata   = man_rdata;
      resp_ph  = 0;
      resp_cnt = 0;
    end else if (rst) begin
      resp_ph  = 0;
      resp_cnt = 0;
    end else if (resp_ph == 0) begin
      if (mem_req) begin
        if (resp_cnt >= resp_aok_dly) begin
          mem_addr_ok = 1'b1;
          resp_addr   = mem_addr;
          resp_ph     = 1;
          resp_cnt    = 0;
        end else begin
          resp_cnt++;
        end
      end
    end else begin
      if (resp_cnt >= resp_dok_dly) begin
        mem_data_ok = 1'b1;
        mem_rdata   = mem_model(resp_addr);
        resp_ph     = 0;
        resp_cnt    = 0;
        dok_count++;
      end else begin
        resp_cnt++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0b want 0", mem_req); end
    n_tests++; if (mem_wr !== 1'b0 || mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL reset_mem_wr: got %0b/%h want 0/0", mem_wr, mem_wstrb); end
    n_tests++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_wdata); end
    n_tests++; if (inst_ok !== 1'b0 || data_ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok: got %0b/%0b want 0/0", inst_ok, data_ok); end
    n_tests++; if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", inst_rdata, data_rdata); end
    rst = 1'b0;
    tick();
    n_tests++; if (mem_req !== 1'b0 || stall_if !== 1'b0 || stall_mem !== 1'b0) begin n_fail++; $display("FAIL idle_quiet: got req=%0b sif=%0b smem=%0b want 0", mem_req, stall_if, stall_mem); end
  endtask

  task automatic test_single_fetch;
    inst_addr = 32'hBFC00000;
    inst_req  = 1'b1;
    #1;
    n_tests++; if (stall_if !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_c0: got sif=%0b req=%0b want 1/0", stall_if, mem_req); end
    tick(); // cycle 1
    n_tests++; if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'hBFC00000) begin n_fail++; $display("FAIL fetch_c1_bus: got req=%0b wr=%0b addr=%h want 1/0/bfc00000", mem_req, mem_wr, mem_addr); end
    n_tests++; if (stall_if !== 1'b1 || inst_ok !== 1'b0) begin n_fail++; $display("FAIL fetch_c1_stall: got sif=%0b ok=%0b want 1/0", stall_if, inst_ok); end
    tick(); // cycle 2
    n_tests++; if (mem_req !== 1'b0 || inst_ok !== 1'b0 || stall_if !== 1'b1) begin n_fail++; $display("FAIL fetch_c2: got req=%0b ok=%0b sif=%0b want 0/0/1", mem_req, inst_ok, stall_if); end
    tick(); // cycle 3
    exp_inst_rdata = 32'h24020001;
    n_tests++; if (inst_ok !== 1'b1 || inst_rdata !== exp_inst_rdata) begin n_fail++; $display("FAIL fetch_c3_ok: got ok=%0b rdata=%h want 1/%h", inst_ok, inst_rdata, exp_inst_rdata); end
    n_tests++; if (stall_if !== 1'b0 || data_ok !== 1'b0) begin n_fail++; $display("FAIL fetch_c3_side: got sif=%0b dok=%0b want 0/0", stall_if, data_ok); end
    inst_req = 1'b0;
    tick(); // cycle 4
    n_tests++; if (inst_ok !== 1'b0 || inst_rdata !== exp_inst_rdata) begin n_fail++; $display("FAIL fetch_c4: got ok=%0b rdata=%h want 0/%h", inst_ok, inst_rdata, exp_inst_rdata); end
  endtask

  task automatic test_store_then_fetch;
    data_req   = 1'b1;
    data_wen   = 4'b0011;
    data_addr  = 32'h80000010;
    data_wdata = 32'h0000BEEF;
    inst_req   = 1'b1;
    inst_addr  = 32'hBFC00100;
    #1;
    n_tests++; if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin n_fail++; $display("FAIL both_c0_stall: got sif=%0b smem=%0b want 1/1", stall_if, stall_mem); end
    tick(); // cycle 1
    n_tests++; if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_wstrb !== 4'b0011) begin n_fail++; $display("FAIL store_c1_ctl: got req=%0b wr=%0b strb=%b want 1/1/0011", mem_req, mem_wr, mem_wstrb); end
    n_tests++; if (mem_addr !== 32'h80000010 || mem_wdata !== 32'h0000BEEF) begin n_fail++; $display("FAIL store_c1_bus: got %h/%h want 80000010/0000beef", mem_addr, mem_wdata); end
    tick(); // cycle 2
    tick(); // cycle 3
    n_tests++; if (data_ok !== 1'b1 || inst_ok !== 1'b0) begin n_fail++; $display("FAIL store_c3_ok: got dok=%0b iok=%0b want 1/0", data_ok, inst_ok); end
    n_tests++; if (data_rdata !== exp_data_rdata) begin n_fail++; $display("FAIL store_rdata_kept: got %h want %h", data_rdata, exp_data_rdata); end
    data_req = 1'b0;
    data_wen = 4'b0000;
    tick(); // cycle 4
    n_tests++; if (data_ok !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL store_c4: got dok=%0b req=%0b want 0/0", data_ok, mem_req); end
    tick(); // cycle 5
    n_tests++; if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_wstrb !== 4'b0000 || mem_addr !== 32'hBFC00100) begin n_fail++; $display("FAIL fetch2_c5: got req=%0b wr=%0b strb=%b addr=%h want 1/0/0000/bfc00100", mem_req, mem_wr, mem_wstrb, mem_addr); end
    tick(); // cycle 6
    n_tests++; if (inst_ok !== 1'b0) begin n_fail++; $display("FAIL fetch2_c6: got ok=%0b want 0", inst_ok); end
    tick(); // cycle 7
    exp_inst_rdata = 32'h0100FEFF;
    n_tests++; if (inst_ok !== 1'b1 || inst_rdata !== exp_inst_rdata) begin n_fail++; $display("FAIL fetch2_c7: got ok=%0b rdata=%h want 1/%h", inst_ok, inst_rdata, exp_inst_rdata); end
    inst_req = 1'b0;
    tick();
  endtask

  task automatic test_slow_memory;
    int req_cycles;
    int ok_cycles;
    req_cycles   = 0;
    ok_cycles    = 0;
    resp_aok_dly = 3;
    resp_dok_dly = 2;
    data_req     = 1'b1;
    data_wen     = 4'b0000;
    data_addr    = 32'h80000020;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (mem_req === 1'b1) req_cycles++;
      if (data_ok === 1'b1) ok_cycles++;
      n_tests++; if (mem_req !== ((c >= 1 && c <= 4) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL slow_req_c%0d: got %0b want %0b", c, mem_req, (c >= 1 && c <= 4)); end
      if (c <= 4) begin
        n_tests++; if (mem_addr !== 32'h80000020) begin n_fail++; $display("FAIL slow_addr_c%0d: got %h want 80000020", c, mem_addr); end
      end
      n_tests++; if (data_ok !== ((c == 8) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL slow_ok_c%0d: got %0b want %0b", c, data_ok, (c == 8)); end
      if (c == 8) begin
        exp_data_rdata = 32'h0020FFDF;
        n_tests++; if (data_rdata !== exp_data_rdata) begin n_fail++; $display("FAIL slow_rdata: got %h want %h", data_rdata, exp_data_rdata); end
        data_req = 1'b0;
      end
    end
    n_tests++; if (req_cycles != 4 || ok_cycles != 1) begin n_fail++; $display("FAIL slow_counts: got req=%0d ok=%0d want 4/1", req_cycles, ok_cycles); end
    resp_aok_dly = 0;
    resp_dok_dly = 0;
  endtask

  task automatic test_cancel;
    int dok_before;
    dok_before   = dok_count;
    resp_dok_dly = 2;
    inst_addr    = 32'hBFC00200;
    inst_req     = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      inst_cancel = 1'b0;
      if (c == 1) begin
        n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL cancel_c1_req: got %0b want 1", mem_req); end
      end
      if (c == 3) begin
        inst_cancel = 1'b1;
        inst_req    = 1'b0;
      end
      n_tests++; if (inst_ok !== 1'b0 || inst_rdata !== exp_inst_rdata) begin n_fail++; $display("FAIL cancel_c%0d: got ok=%0b rdata=%h want 0/%h", c, inst_ok, inst_rdata, exp_inst_rdata); end
    end
    n_tests++; if (dok_count != dok_before + 1) begin n_fail++; $display("FAIL cancel_bus_done: got %0d want %0d", dok_count - dok_before, 1); end
    resp_dok_dly = 0;
    // next fetch after a cancel must complete normally
    inst_addr = 32'hBFC00000;
    inst_req  = 1'b1;
    tick();
    tick();
    tick();
    exp_inst_rdata = 32'h24020001;
    n_tests++; if (inst_ok !== 1'b1 || inst_rdata !== exp_inst_rdata) begin n_fail++; $display("FAIL after_cancel_fetch: got ok=%0b rdata=%h want 1/%h", inst_ok, inst_rdata, exp_inst_rdata); end
    inst_req = 1'b0;
    tick();
  endtask

  task automatic test_cancel_data;
    data_req    = 1'b1;
    data_wen    = 4'b0000;
    data_addr   = 32'h80000040;
    inst_cancel = 1'b1;
    tick();
    tick();
    tick();
    exp_data_rdata = 32'h0040FFBF;
    n_tests++; if (data_ok !== 1'b1 || data_rdata !== exp_data_rdata) begin n_fail++; $display("FAIL cancel_data: got ok=%0b rdata=%h want 1/%h", data_ok, data_rdata, exp_data_rdata); end
    data_req    = 1'b0;
    inst_cancel = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_wait;
    resp_manual = 1'b1;
    man_aok     = 1'b0;
    man_dok     = 1'b0;
    inst_addr   = 32'hBFC00000;
    inst_req    = 1'b1;
    tick(); // cycle 1: REQ
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstw_c1_req: got %0b want 1", mem_req); end
    man_aok = 1'b1;
    tick(); // cycle 2: WAIT
    man_aok = 1'b0;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rstw_c2_req: got %0b want 0", mem_req); end
    rst      = 1'b1;
    inst_req = 1'b0;
    tick(); // cycle 3
    exp_inst_rdata = 32'h0;
    exp_data_rdata = 32'h0;
    n_tests++; if (mem_req !== 1'b0 || inst_ok !== 1'b0 || data_ok !== 1'b0 || inst_rdata !== 32'h0) begin n_fail++; $display("FAIL rstw_c3: got req=%0b iok=%0b dok=%0b rdata=%h want 0/0/0/0", mem_req, inst_ok, data_ok, inst_rdata); end
    rst       = 1'b0;
    man_dok   = 1'b1;
    man_rdata = 32'h11111111;
    tick(); // cycle 4
    man_dok = 1'b0;
    n_tests++; if (mem_req !== 1'b0 || inst_ok !== 1'b0 || data_ok !== 1'b0 || inst_rdata !== 32'h0) begin n_fail++; $display("FAIL rstw_late_dok: got req=%0b iok=%0b dok=%0b rdata=%h want 0/0/0/0", mem_req, inst_ok, data_ok, inst_rdata); end
    tick();
    n_tests++; if (inst_ok !== 1'b0 || data_ok !== 1'b0) begin n_fail++; $display("FAIL rstw_c5: got iok=%0b dok=%0b want 0/0", inst_ok, data_ok); end
    resp_manual = 1'b0;
    tick();
    inst_req = 1'b1;
    tick();
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'hBFC00000) begin n_fail++; $display("FAIL rstw_fresh_req: got %0b/%h want 1/bfc00000", mem_req, mem_addr); end
    tick();
    tick();
    exp_inst_rdata = 32'h24020001;
    n_tests++; if (inst_ok !== 1'b1 || inst_rdata !== exp_inst_rdata) begin n_fail++; $display("FAIL rstw_fresh_ok: got ok=%0b rdata=%h want 1/%h", inst_ok, inst_rdata, exp_inst_rdata); end
    inst_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    int  ndok;
    int  t1;
    int  t2;
    bit  inst_early;
    bit  got_inst;
    ndok       = 0;
    t1         = 0;
    t2         = 0;
    inst_early = 1'b0;
    got_inst   = 1'b0;
    data_req   = 1'b1;
    data_wen   = 4'b0000;
    data_addr  = 32'h80000100;
    inst_req   = 1'b1;
    inst_addr  = 32'hBFC00300;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (mem_req === 1'b1 && mem_addr === 32'hBFC00300 && ndok < 2) inst_early = 1'b1;
      if (data_ok === 1'b1) begin
        ndok++;
        if (ndok == 1) begin
          t1 = c;
          n_tests++; if (data_rdata !== 32'h0100FEFF) begin n_fail++; $display("FAIL b2b_rdata1: got %h want 0100feff", data_rdata); end
          data_addr = 32'h80000104;
        end else if (ndok == 2) begin
          t2 = c;
          n_tests++; if (data_rdata !== 32'h0104FEFB) begin n_fail++; $display("FAIL b2b_rdata2: got %h want 0104fefb", data_rdata); end
          data_req = 1'b0;
        end
      end
      if (inst_ok === 1'b1) begin
        got_inst = 1'b1;
        inst_req = 1'b0;
        n_tests++; if (inst_rdata !== 32'h0300FCFF) begin n_fail++; $display("FAIL b2b_inst_rdata: got %h want 0300fcff", inst_rdata); end
      end
      if (got_inst && ndok >= 2) break;
    end
    n_tests++; if (ndok != 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", ndok); end
    n_tests++; if (t1 != 3) begin n_fail++; $display("FAIL b2b_first_ok: got cycle %0d want 3", t1); end
    n_tests++; if (t2 - t1 < 4) begin n_fail++; $display("FAIL b2b_gap: got %0d want >=4", t2 - t1); end
    n_tests++; if (inst_early !== 1'b0) begin n_fail++; $display("FAIL b2b_inst_between: got %0b want 0", inst_early); end
    n_tests++; if (got_inst !== 1'b1) begin n_fail++; $display("FAIL b2b_inst_served: got %0b want 1", got_inst); end
    data_req = 1'b0;
    inst_req = 1'b0;
    tick();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_store_then_fetch();
    test_slow_memory();
    test_cancel();
    test_cancel_data();
    test_reset_in_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
